// File: rtl/lcd_status_reader_if.sv
// Signal bundle between the status reader and the LCD pads / requester.
// The controller uses the master view; the pad/requester side uses slave.
interface lcd_status_reader_if;
    logic       start;
    logic [3:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       lcd_oe;
    logic       reading;
    logic       busy;
    logic [6:0] address;
    logic       read_done;

    modport master (
        input  start, lcd_data,
        output lcd_rs, lcd_rw, lcd_e, lcd_oe,
        output reading, busy, address, read_done
    );

    modport slave (
        output start, lcd_data,
        input  lcd_rs, lcd_rw, lcd_e, lcd_oe,
        input  reading, busy, address, read_done
    );
endinterface

// File: rtl/lcd_status_reader.sv
// HD44780-style busy-flag / address-counter read over a 4-bit bus.
// Two E strobes fetch the upper and lower nibble; results are registered.
module lcd_status_reader #(
    parameter int unsigned SETUP_CYCLES = 3,
    parameter int unsigned EHIGH_CYCLES = 12,
    parameter int unsigned GAP_CYCLES   = 50
) (
    input logic               clk,
    input logic               rst_n,
    lcd_status_reader_if.master bus
);

    localparam logic [7:0] SETUP_N = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] EHIGH_N = 8'(EHIGH_CYCLES - 1);
    localparam logic [7:0] GAP_N   = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        E_HI1,
        GAP,
        E_HI2,
        HOLD,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic [3:0] upper;
    logic [3:0] lower;

    logic e_nx;
    logic rw_nx;
    logic reading_nx;
    logic done_nx;

    logic       lcd_e;
    logic       lcd_rw;
    logic       lcd_oe;
    logic       reading;
    logic       busy;
    logic [6:0] address;
    logic       read_done;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = SETUP;
                    cnt_nx   = SETUP_N;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_nx = E_HI1;
                    cnt_nx   = EHIGH_N;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            E_HI1: begin
                if (cnt == 8'd0) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_N;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            GAP: begin
                if (cnt == 8'd0) begin
                    state_nx = E_HI2;
                    cnt_nx   = EHIGH_N;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            E_HI2: begin
                if (cnt == 8'd0) begin
                    state_nx = HOLD;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            HOLD: state_nx = DONE;
            DONE: state_nx = IDLE;
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so pins
    // change on the same edge as the state and never glitch on inputs.
    always_comb begin
        e_nx       = (state_nx == E_HI1) || (state_nx == E_HI2);
        rw_nx      = (state_nx != IDLE) && (state_nx != DONE);
        reading_nx = rw_nx;
        done_nx    = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            upper     <= 4'd0;
            lower     <= 4'd0;
            lcd_e     <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_oe    <= 1'b1;
            reading   <= 1'b0;
            read_done <= 1'b0;
            busy      <= 1'b1;
            address   <= 7'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            lcd_e     <= e_nx;
            lcd_rw    <= rw_nx;
            lcd_oe    <= !rw_nx;
            reading   <= reading_nx;
            read_done <= done_nx;
            if (state == E_HI1 && state_nx == GAP)
                upper <= bus.lcd_data;
            if (state == E_HI2 && state_nx == HOLD)
                lower <= bus.lcd_data;
            if (state == HOLD)
                {busy, address} <= {upper, lower};
        end
    end

    assign bus.lcd_rs    = 1'b0;
    assign bus.lcd_e     = lcd_e;
    assign bus.lcd_rw    = lcd_rw;
    assign bus.lcd_oe    = lcd_oe;
    assign bus.reading   = reading;
    assign bus.busy      = busy;
    assign bus.address   = address;
    assign bus.read_done = read_done;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Bench for lcd_status_reader: LCD nibble model feeds a scoreboard that
// a negedge monitor drains on every read_done, plus strobe timing checks.
module tb_lcd_status_reader;

    localparam int S   = 3;
    localparam int EH  = 12;
    localparam int G   = 50;
    localparam int LAT = S + 2 * EH + G + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    logic [7:0] exp_q[$];
    logic [3:0] force_q[$];

    lcd_status_reader_if bus ();

    lcd_status_reader #(
        .SETUP_CYCLES(S),
        .EHIGH_CYCLES(EH),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // LCD: a fresh nibble appears on every E rise; the word is known
    // once the second nibble is issued.
    logic [3:0] lcd_up;
    bit         lcd_ph;
    logic       lcd_le;
    always @(negedge clk) begin
        logic [3:0] nib;
        if (!rst_n) begin
            lcd_ph = 1'b0;
            lcd_le = 1'b0;
        end else begin
            if (bus.lcd_e && !lcd_le) begin
                if (force_q.size() > 0) nib = force_q.pop_front();
                else nib = 4'($urandom_range(0, 15));
                bus.lcd_data = nib;
                if (!lcd_ph) begin
                    lcd_up = nib;
                    lcd_ph = 1'b1;
                end else begin
                    exp_q.push_back({lcd_up, nib});
                    lcd_ph = 1'b0;
                end
            end
            lcd_le = bus.lcd_e;
        end
    end

    // Monitor: scoreboard, latency, strobe widths, pin exclusivity.
    logic [7:0] last_exp = 8'h80;
    int   rise_cyc = 0;
    int   n_e = 0;
    int   hi = 0;
    int   lo = 0;
    logic prev_e = 1'b0;
    logic prev_rd = 1'b0;
    always @(negedge clk) begin
        logic [7:0] e;
        if (mon_en) begin
            if (!rst_n) begin
                exp_q.delete();
                last_exp = 8'h80;
                prev_e = 1'b0;
                prev_rd = 1'b0;
                hi = 0;
                lo = 0;
            end else begin
                if (bus.lcd_oe && bus.lcd_rw)
                    chk("oe_rw_excl", 1, 0);
                if (bus.lcd_e && !bus.lcd_rw)
                    chk("e_needs_rw", 0, 1);
                if (bus.reading && !prev_rd) begin
                    rise_cyc = cyc;
                    n_e = 0;
                end
                if (bus.lcd_e && !prev_e) begin
                    if (n_e == 0) chk("setup_len", cyc - rise_cyc, S);
                    else chk("gap_len", lo, G);
                    n_e++;
                    hi = 0;
                end
                if (!bus.lcd_e && prev_e) chk("e_high_len", hi, EH);
                if (bus.lcd_e) hi++;
                if (!bus.lcd_e && prev_e) lo = 0;
                if (!bus.lcd_e) lo++;
                if (bus.read_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy", int'(bus.busy), int'(e[7]));
                        chk("address", int'(bus.address), int'(e[6:0]));
                        chk("latency", cyc - rise_cyc + 1, LAT);
                        chk("strobes", n_e, 2);
                        last_exp = e;
                    end
                end else if (!bus.reading) begin
                    chk("hold_value", int'({bus.busy, bus.address}),
                        int'(last_exp));
                end
                prev_e = bus.lcd_e;
                prev_rd = bus.reading;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (bus.read_done) seen = 1'b1;
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_e(input logic lvl, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (bus.lcd_e == lvl) seen = 1'b1;
        end
        if (!seen) chk("e_wait_timeout", int'(!lvl), int'(lvl));
    endtask

    task automatic check_idle_pins(input string name);
        chk({name, "_e"}, int'(bus.lcd_e), 0);
        chk({name, "_rw"}, int'(bus.lcd_rw), 0);
        chk({name, "_rs"}, int'(bus.lcd_rs), 0);
        chk({name, "_oe"}, int'(bus.lcd_oe), 1);
        chk({name, "_reading"}, int'(bus.reading), 0);
        chk({name, "_done"}, int'(bus.read_done), 0);
        chk({name, "_busy"}, int'(bus.busy), 1);
        chk({name, "_addr"}, int'(bus.address), 0);
    endtask

    initial begin
        int ndone;
        int dcyc;
        logic prd;

        bus.start = 1'b0;
        bus.lcd_data = 4'h0;
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_idle_pins("reset");
        bus.start = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);

        force_q.push_back(4'h8);
        force_q.push_back(4'h5);
        pulse_start();
        wait_done("read_85", 200);
        @(negedge clk);
        chk("read_85_busy", int'(bus.busy), 1);
        chk("read_85_addr", int'(bus.address), 'h05);

        force_q.push_back(4'h2);
        force_q.push_back(4'hA);
        pulse_start();
        wait_done("read_2a", 200);
        repeat (20) @(negedge clk);
        chk("read_2a_busy", int'(bus.busy), 0);
        chk("read_2a_addr", int'(bus.address), 'h2A);

        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            pulse_start();
            if ($urandom_range(0, 1) == 1) begin
                wait_e(1'b1, 20);
                @(posedge clk);
                #1 bus.start = 1'b1;
                @(posedge clk);
                #1 bus.start = 1'b0;
            end
            wait_done("rand_read", 200);
        end

        @(posedge clk);
        #1 bus.start = 1'b1;
        ndone = 0;
        dcyc = 0;
        prd = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.reading && !prd && ndone > 0)
                chk("b2b_spacing", cyc - dcyc, 2);
            if (bus.read_done) begin
                ndone++;
                dcyc = cyc;
            end
            prd = bus.reading;
        end
        chk("held_reads", ndone, 2);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done("held_tail", 200);

        repeat (4) @(posedge clk);
        pulse_start();
        wait_e(1'b1, 20);
        wait_e(1'b0, 20);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 check_idle_pins("gap_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.read_done) chk("abort_no_done", 1, 0);
        end
        chk("abort_busy", int'(bus.busy), 1);
        chk("abort_addr", int'(bus.address), 0);

        pulse_start();
        wait_done("post_reset_read", 200);
        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lcd_status_reader.md
LCD_STATUS_READER -- requirements
Module: lcd_status_reader

Parameters
REQ-001 SETUP_CYCLES, 3, cycles with RS/RW stable and E low before each first E rise (60 ns at 50 MHz).
REQ-002 EHIGH_CYCLES, 12, cycles E held high per nibble (240 ns).
REQ-003 GAP_CYCLES, 50, cycles E held low between upper and lower nibble (1 us).
REQ-004 All parameters SHALL be in the range 1..255.

Interface
REQ-005 Clock  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-006 Reset  input  1  synchronous, active-low reset.
REQ-007 iStart  input  1  request one busy-flag/address read; sampled only in IDLE.
REQ-008 iLCD_Data  input  4  LCD DB7..DB4 from the pad tristate.
REQ-009 oLCD_RS  output  1  register select; 0 for the whole read.
REQ-010 oLCD_RW  output  1  1 from SETUP through HOLD, else 0.
REQ-011 oLCD_Enabled  output  1  LCD E strobe.
REQ-012 oLCD_DataOE  output  1  FPGA data-driver enable; 0 whenever oLCD_RW=1.
REQ-013 oReading  output  1  1 in every state except IDLE and DONE.
REQ-014 oBusy  output  1  last captured busy flag (DB7 of upper nibble).
REQ-015 oAddress  output  7  last captured address counter.
REQ-016 oReadDone  output  1  one-cycle pulse when oBusy/oAddress are updated.

Function
REQ-017 All outputs SHALL be registered; no output SHALL depend combinationally on an input.
REQ-018 States SHALL be IDLE, SETUP, E_HI1, GAP, E_HI2, HOLD, DONE; a single 8-bit down/up cycle counter SHALL time SETUP, E_HI1, GAP and E_HI2.
REQ-019 IDLE: E=0, RW=0, RS=0, OE=1; iStart=1 at an edge -> SETUP, otherwise stay.
REQ-020 SETUP: E=0, RW=1, OE=0 for exactly SETUP_CYCLES cycles -> E_HI1.
REQ-021 E_HI1: E=1 for exactly EHIGH_CYCLES cycles; on the edge leaving E_HI1, iLCD_Data SHALL be captured as the upper nibble -> GAP.
REQ-022 GAP: E=0, RW=1 for exactly GAP_CYCLES cycles -> E_HI2.
REQ-023 E_HI2: E=1 for exactly EHIGH_CYCLES cycles; on the edge leaving E_HI2, iLCD_Data SHALL be captured as the lower nibble -> HOLD.
REQ-024 HOLD: E=0, RW=1, OE=0 for 1 cycle, satisfying data hold time -> DONE.
REQ-025 DONE: RW=0, OE=1, oReadDone=1 for 1 cycle; oBusy=upper[3], oAddress={upper[2:0],lower[3:0]} valid from this cycle -> IDLE.
REQ-026 Latency: oReadDone SHALL assert SETUP_CYCLES+2*EHIGH_CYCLES+GAP_CYCLES+2 cycles after the edge that samples iStart (79 with defaults).
REQ-027 iStart SHALL be ignored outside IDLE; iStart held high SHALL start back-to-back reads with exactly one IDLE cycle between DONE and SETUP.
REQ-028 oBusy/oAddress SHALL hold their values between reads and change only at the DONE entry edge.
REQ-029 OE=1 and RW=1 SHALL never be asserted in the same cycle, including across state transitions.

Reset
REQ-030 Reset=0 at any edge SHALL force IDLE, counter=0, oLCD_Enabled=0, oLCD_RW=0, oLCD_RS=0, oLCD_DataOE=1, oReading=0, oReadDone=0, oBusy=1, oAddress=0, overriding iStart.
REQ-031 Reset mid-read SHALL abort without an oReadDone pulse and without updating oBusy/oAddress beyond their reset values.

Verification
REQ-032 Reset low 2 cycles, then high -> all outputs at REQ-030 values, oBusy=1, FSM in IDLE.
REQ-033 iStart pulse, LCD model drives 0x8 on the first E and 0x5 on the second -> E high for 12 cycles twice with 50 low cycles between; oReadDone at cycle 79; oBusy=1, oAddress=0x05.
REQ-034 LCD model drives 0x2 then 0xA -> oBusy=0, oAddress=0x2A; values held until the next read.
REQ-035 iStart held high for 200 cycles -> two complete reads, DONE->IDLE->SETUP spacing of one cycle; iStart pulses during E_HI1 are ignored.
REQ-036 Reset asserted during GAP -> E=0, RW=0 and OE=1 next cycle, no oReadDone pulse, oBusy=1 and oAddress=0.
REQ-037 Assertion every cycle: never (oLCD_DataOE && oLCD_RW); oLCD_RW=1 whenever oLCD_Enabled=1.
